// File: rtl/block_feeder_pkg.sv
// Shared constants for the falling-blocks obstacle feeder: field geometry, LFSR taps, FSM codes
// and the helper that turns an LFSR value into a passable obstacle row.
package block_feeder_pkg;

   localparam int unsigned ROW_W = 8;
   localparam int unsigned ROWS  = 8;

   localparam logic [15:0] LFSR_MASK = 16'hB400;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StHalt = 2'd2;

   // Full rows lose one bit and empty rows gain one, so every obstacle row stays passable.
   function automatic logic [ROW_W-1:0] obstacle_row(input logic [15:0] lfsr);
      logic [ROW_W-1:0] row;
      row = lfsr[ROW_W-1:0];
      if (row == 8'hFF) begin
         row[lfsr[10:8]] = 1'b0;
      end else if (row == 8'h00) begin
         row[lfsr[10:8]] = 1'b1;
      end
      return row;
   endfunction

endpackage

// File: rtl/block_lfsr.sv
// 16-bit right-shifting Galois LFSR with an advance enable; a zero seed is replaced by 1 so the
// register can never lock up.
module block_lfsr
   import block_feeder_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        advance,
   output logic [15:0] value
);

   localparam logic [15:0] SeedSafe = (SEED == 16'h0000) ? 16'h0001 : SEED;

   logic [15:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (advance) begin
         lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr_q <= SeedSafe;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign value = lfsr_q;

endmodule

// File: rtl/block_feeder.sv
// Generates and scrolls the 8x8 obstacle field: a new row enters at the top on each scroll tick,
// the tick period shortens as obstacle rows pass the player, and gameover freezes the field.
module block_feeder
   import block_feeder_pkg::*;
#(
   parameter int unsigned TICK_DIV  = 25_000_000,
   parameter int unsigned TICK_STEP = 1_000_000,
   parameter int unsigned TICK_MIN  = 5_000_000,
   parameter int unsigned ROW_GAP   = 2,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  gameover,
   output logic [ROWS*ROW_W-1:0] blocks,
   output logic                  step,
   output logic [15:0]           score,
   output logic [3:0]            level,
   output logic                  running
);

   localparam logic [2:0] GapLoad = 3'(ROW_GAP);

   logic [1:0]            state_q, state_d;
   logic [31:0]           cnt_q, cnt_d;
   logic [ROWS*ROW_W-1:0] blocks_q, blocks_d;
   logic                  step_q, step_d;
   logic [15:0]           score_q, score_d;
   logic [2:0]            gap_q, gap_d;
   logic                  running_q, running_d;

   logic [15:0]      lfsr;
   logic             lfsr_advance;
   logic [ROW_W-1:0] new_row;
   logic [3:0]       level_w;
   logic [31:0]      dec;
   logic [31:0]      period;
   logic             tick;

   block_lfsr #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .advance (lfsr_advance),
      .value   (lfsr)
   );

   assign level_w = (score_q[15:3] > 13'd15) ? 4'hF : score_q[6:3];

   // Clamp before subtracting so a large level can never wrap the period.
   always_comb begin
      dec = {28'd0, level_w} * TICK_STEP;
      if ((TICK_DIV > TICK_MIN) && (dec < (TICK_DIV - TICK_MIN))) begin
         period = TICK_DIV - dec;
      end else begin
         period = TICK_MIN;
      end
   end

   // >= lets a period that shrank mid-count fire on the next cycle instead of wrapping.
   assign tick = (state_q == StRun) && ((period <= 32'd1) || (cnt_q >= (period - 32'd1)));

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      blocks_d     = blocks_q;
      step_d       = 1'b0;
      score_d      = score_q;
      gap_d        = gap_q;
      lfsr_advance = 1'b0;
      new_row      = '0;
      case (state_q)
         StIdle: begin
            if (start && !gameover) begin
               state_d = StRun;
               cnt_d   = '0;
            end
         end
         StRun: begin
            if (gameover) begin
               state_d = StHalt;
            end else if (tick) begin
               cnt_d  = '0;
               step_d = 1'b1;
               if (gap_q == 3'd0) begin
                  new_row      = obstacle_row(lfsr);
                  gap_d        = GapLoad;
                  lfsr_advance = 1'b1;
               end else begin
                  gap_d = gap_q - 3'd1;
               end
               blocks_d = {new_row, blocks_q[ROWS*ROW_W-1:ROW_W]};
               if ((blocks_q[ROW_W-1:0] != '0) && (score_q != 16'hFFFF)) begin
                  score_d = score_q + 16'd1;
               end
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         StHalt: begin
            state_d = StHalt;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      running_d = (state_d == StRun);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         blocks_q  <= '0;
         step_q    <= 1'b0;
         score_q   <= '0;
         gap_q     <= '0;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         blocks_q  <= blocks_d;
         step_q    <= step_d;
         score_q   <= score_d;
         gap_q     <= gap_d;
         running_q <= running_d;
      end
   end

   assign blocks  = blocks_q;
   assign step    = step_q;
   assign score   = score_q;
   assign level   = level_w;
   assign running = running_q;

endmodule

// File: tb/tb_block_feeder.sv
// Directed bench for block_feeder with a short scroll period; two extra instances exercise the
// obstacle-row overrides for full and empty LFSR low bytes.
module tb_block_feeder;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        gameover;
   logic        gnd;

   logic [63:0] blocks, blocks_ff, blocks_05;
   logic        step, step_ff, step_05;
   logic [15:0] score, score_ff, score_05;
   logic [3:0]  level, level_ff, level_05;
   logic        running, running_ff, running_05;

   int total = 0;
   int bad   = 0;

   logic [63:0] blocks_m;
   logic [15:0] lfsr_m;

   always #5 clk = ~clk;

   block_feeder #(
      .TICK_DIV (4), .TICK_STEP (1), .TICK_MIN (2), .ROW_GAP (1), .LFSR_SEED (16'hACE1)
   ) dut (
      .clk (clk), .rst (rst), .start (start), .gameover (gameover),
      .blocks (blocks), .step (step), .score (score), .level (level), .running (running)
   );

   block_feeder #(
      .TICK_DIV (4), .TICK_STEP (1), .TICK_MIN (2), .ROW_GAP (1), .LFSR_SEED (16'h00FF)
   ) dut_ff (
      .clk (clk), .rst (rst), .start (start), .gameover (gnd),
      .blocks (blocks_ff), .step (step_ff), .score (score_ff), .level (level_ff),
      .running (running_ff)
   );

   block_feeder #(
      .TICK_DIV (4), .TICK_STEP (1), .TICK_MIN (2), .ROW_GAP (1), .LFSR_SEED (16'h0500)
   ) dut_05 (
      .clk (clk), .rst (rst), .start (start), .gameover (gnd),
      .blocks (blocks_05), .step (step_05), .score (score_05), .level (level_05),
      .running (running_05)
   );

   function automatic logic [15:0] m_next(input logic [15:0] v);
      return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
   endfunction

   function automatic logic [7:0] m_row(input logic [15:0] v);
      logic [7:0] r;
      r = v[7:0];
      if (r == 8'hFF) r = r & ~(8'h01 << v[10:8]);
      else if (r == 8'h00) r = 8'h01 << v[10:8];
      return r;
   endfunction

   // Score after scroll step n: obstacle i enters on step 2i-1 and leaves row 0 on step 2i+7.
   function automatic int m_score(input int n);
      return (n >= 9) ? (n - 7) / 2 : 0;
   endfunction

   function automatic int m_level(input int sc);
      return ((sc >> 3) > 15) ? 15 : (sc >> 3);
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst      = 1'b0;
      start    = 1'b0;
      gameover = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic test_reset;
      logic seen_step;
      logic seen_blk;
      logic seen_run;
      gnd      = 1'b0;
      rst      = 1'b0;
      start    = 1'b0;
      gameover = 1'b0;
      #2;
      total++;
      if (blocks !== 64'h0 || step !== 1'b0 || score !== 16'h0 || level !== 4'h0 ||
          running !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: blocks=%h step=%b score=%0d level=%0d running=%b (want 0)",
                  blocks, step, score, level, running);
      end
      tick();
      rst = 1'b1;
      seen_step = 1'b0;
      seen_blk  = 1'b0;
      seen_run  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (step !== 1'b0) seen_step = 1'b1;
         if (blocks !== 64'h0) seen_blk = 1'b1;
         if (running !== 1'b0) seen_run = 1'b1;
      end
      total++;
      if (seen_step || seen_blk || seen_run) begin
         bad++;
         $display("FAIL idle_quiet: step_seen=%b blocks_seen=%b running_seen=%b (want 0 0 0)",
                  seen_step, seen_blk, seen_run);
      end
   endtask

   task automatic wait_quiet(input int n, input string name);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (step !== 1'b0) seen = 1'b1;
      end
      total++;
      if (seen) begin
         bad++;
         $display("FAIL %s: step went high early (want 0 for %0d cycles)", name, n);
      end
   endtask

   task automatic test_start;
      total++;
      if (running !== 1'b0) begin
         bad++;
         $display("FAIL pre_start_idle: running=%b want 0", running);
      end
      start = 1'b1;
      tick();
      total++;
      if (running !== 1'b1 || step !== 1'b0) begin
         bad++;
         $display("FAIL start_run: running=%b step=%b want 1 0", running, step);
      end
      wait_quiet(3, "first_interval");
      tick();
      total++;
      if (step !== 1'b1 || blocks !== 64'hE100_0000_0000_0000 || score !== 16'd0) begin
         bad++;
         $display("FAIL first_step: step=%b blocks=%h score=%0d want 1 e100000000000000 0",
                  step, blocks, score);
      end
      wait_quiet(3, "second_interval");
      tick();
      total++;
      if (step !== 1'b1 || blocks !== 64'h00E1_0000_0000_0000) begin
         bad++;
         $display("FAIL second_step: step=%b blocks=%h want 1 00e1000000000000", step, blocks);
      end
      wait_quiet(3, "third_interval");
      tick();
      total++;
      if (step !== 1'b1 || blocks !== 64'h7000_E100_0000_0000) begin
         bad++;
         $display("FAIL third_step: step=%b blocks=%h want 1 7000e10000000000", step, blocks);
      end
   endtask

   task automatic test_scoring;
      int per;
      int sc;
      logic [7:0] row;
      lfsr_m   = m_next(16'hE270);
      blocks_m = 64'h7000_E100_0000_0000;
      for (int n = 4; n <= 41; n++) begin
         per = 4 - m_level(m_score(n - 1));
         if (per < 2) per = 2;
         if (n % 2 == 1) begin
            row    = m_row(lfsr_m);
            lfsr_m = m_next(lfsr_m);
         end else begin
            row = 8'h00;
         end
         blocks_m = {row, blocks_m[63:8]};
         sc = m_score(n);
         for (int i = 0; i < per - 1; i++) tick();
         total++;
         if (step !== 1'b0) begin
            bad++;
            $display("FAIL interval_early n=%0d: step=1 one cycle before period %0d", n, per);
         end
         tick();
         total++;
         if (step !== 1'b1) begin
            bad++;
            $display("FAIL interval_step n=%0d: step=%b want 1 (period %0d)", n, step, per);
         end
         total++;
         if (blocks !== blocks_m) begin
            bad++;
            $display("FAIL field n=%0d: blocks=%h want %h", n, blocks, blocks_m);
         end
         total++;
         if (score !== 16'(sc) || level !== 4'(m_level(sc))) begin
            bad++;
            $display("FAIL score n=%0d: score=%0d level=%0d want %0d %0d", n, score, level, sc,
                     m_level(sc));
         end
      end
   endtask

   task automatic test_halt;
      logic seen_step;
      logic seen_run;
      // Period is 2 here: one cycle after a step the counter sits at period-1.
      tick();
      gameover = 1'b1;
      tick();
      total++;
      if (step !== 1'b0 || blocks !== blocks_m || running !== 1'b0 || score !== 16'd17) begin
         bad++;
         $display("FAIL halt_edge: step=%b blocks=%h running=%b score=%0d want 0 %h 0 17",
                  step, blocks, running, score, blocks_m);
      end
      seen_step = 1'b0;
      seen_run  = 1'b0;
      for (int i = 0; i < 50; i++) begin
         start = (i % 3 == 0);
         if (i == 10) gameover = 1'b0;
         tick();
         if (step !== 1'b0) seen_step = 1'b1;
         if (running !== 1'b0) seen_run = 1'b1;
      end
      total++;
      if (seen_step || seen_run || blocks !== blocks_m || score !== 16'd17) begin
         bad++;
         $display("FAIL halt_frozen: step_seen=%b run_seen=%b blocks=%h score=%0d want 0 0 %h 17",
                  seen_step, seen_run, blocks, score, blocks_m);
      end
   endtask

   task automatic test_seeds;
      do_reset();
      start = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) tick();
      total++;
      if (step_ff !== 1'b1 || blocks_ff !== 64'hFE00_0000_0000_0000) begin
         bad++;
         $display("FAIL seed_00ff: step=%b blocks=%h want 1 fe00000000000000", step_ff, blocks_ff);
      end
      total++;
      if (step_05 !== 1'b1 || blocks_05 !== 64'h2000_0000_0000_0000) begin
         bad++;
         $display("FAIL seed_0500: step=%b blocks=%h want 1 2000000000000000", step_05, blocks_05);
      end
   endtask

   task automatic test_reset_mid;
      // Continues from step 1 of the seed run; steps 2..10 follow at 4-cycle spacing.
      for (int i = 0; i < 36; i++) tick();
      total++;
      if (step !== 1'b1 || score !== 16'd1 || blocks === 64'h0) begin
         bad++;
         $display("FAIL pre_reset: step=%b score=%0d blocks=%h want 1 1 nonzero",
                  step, score, blocks);
      end
      #1;
      rst = 1'b0;
      #1;
      total++;
      if (blocks !== 64'h0 || score !== 16'h0 || step !== 1'b0 || running !== 1'b0 ||
          level !== 4'h0) begin
         bad++;
         $display("FAIL async_reset: blocks=%h score=%0d step=%b running=%b level=%0d want 0",
                  blocks, score, step, running, level);
      end
      start = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      total++;
      if (running !== 1'b0 || blocks !== 64'h0 || step !== 1'b0) begin
         bad++;
         $display("FAIL post_reset_idle: running=%b blocks=%h step=%b want 0 0 0",
                  running, blocks, step);
      end
      test_start();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_start();
      test_scoring();
      test_halt();
      test_seeds();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/block_feeder.md
Name: block_feeder

Overview:
Upstream stage of the falling-blocks game that generates and scrolls the 8x8 obstacle field consumed by the collision judge.
- blocks[7:0] is the bottom (player) row and blocks[63:56] is the top row.
- On every scroll step the field shifts down one row and a new row enters at the top.
- New obstacle rows come from an LFSR and are always passable; empty gap rows are inserted between obstacle rows.
- Scroll speed rises with the number of obstacle rows passed; scrolling freezes when the judge reports gameover.

Parameters:
TICK_DIV, 25_000_000, initial scroll period in clk cycles (level 0)
TICK_STEP, 1_000_000, period reduction per level
TICK_MIN, 5_000_000, lower bound on scroll period
ROW_GAP, 2, empty rows inserted after each obstacle row (0..7)
LFSR_SEED, 16'hACE1, LFSR reset value (16'h0000 is replaced by 16'h0001)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
start  in  1  level; begins scrolling from IDLE
gameover  in  1  from judge; freezes field
blocks  out  64  obstacle field, row r = blocks[8r+7:8r], r=0 bottom
step  out  1  one-cycle pulse, high on the cycle blocks has just updated
score  out  16  obstacle rows passed, saturating
level  out  4  min(score>>3, 15)
running  out  1  high in RUN

Behaviour:
- Reset (rst=0, async): state=IDLE, blocks=0, step=0, score=0, level=0, running=0, tick counter=0, lfsr=LFSR_SEED, gap counter=0.
- States:
  - IDLE: start=1 and gameover=0 -> RUN; tick counter cleared. gameover is ignored in IDLE.
  - RUN: gameover=1 -> HALT at the next edge. gameover has priority over a coincident tick, so no shift occurs on that edge.
  - HALT: blocks, score and level hold; step=0. Only reset leaves HALT; start is ignored.
- Period: period = max(TICK_MIN, TICK_DIV - level*TICK_STEP), 32-bit unsigned, no underflow (clamp before subtract).
- Tick: in RUN the counter increments each cycle. When counter >= period-1, a step occurs and the counter returns to 0. Using >= means a shortened period mid-count fires on the next cycle rather than wrapping.
- Step actions, all on the same edge:
  - blocks <= {new_row, blocks[63:8]}.
  - If the old blocks[7:0] != 0, score <= score+1, saturating at 16'hFFFF; level follows combinationally from the registered score.
  - step <= 1 for exactly one cycle.
- New row selection:
  - If the gap counter = 0, the row is an obstacle row; the gap counter is loaded with ROW_GAP and the LFSR advances once.
  - Otherwise new_row=8'h00 and the gap counter decrements.
  - Obstacle row = lfsr[7:0], with two overrides: 8'hFF -> clear bit lfsr[10:8]; 8'h00 -> set bit lfsr[10:8]. The row is therefore never full and never empty.
  - Row is taken from the LFSR value before the advance.
- LFSR: 16-bit Galois, right shift, mask 16'hB400. It advances only on obstacle-row steps, which makes the sequence deterministic per seed.
- running = (state==RUN), registered.
- Reset mid-operation: everything returns to reset values immediately, with no residual step pulse.

Decomposition:
- Shared package: state encoding (IDLE/RUN/HALT), LFSR mask 16'hB400, ROW_W=8, ROWS=8.
- One sub-module: block_lfsr (16-bit Galois LFSR with seed parameter, advance enable, zero-seed guard).
- Tick counter, period calculation, gap counter and FSM stay in block_feeder.

Test Plan (TICK_DIV=4, TICK_STEP=1, TICK_MIN=2, ROW_GAP=1, LFSR_SEED=16'hACE1):
1. Reset then idle 20 cycles, start=0 -> blocks=0, step never high, running=0.
2. start=1 -> running=1. Four cycles later step=1 and blocks=64'hE100_0000_0000_0000. Next step (4 cycles later) gives blocks=64'h00E1_0000_0000_0000. Third step puts the next obstacle row (LFSR advanced from ACE1, low byte with overrides applied) in [63:56].
3. Run until the E1 row leaves blocks[7:0] -> score goes 0->1 on that step. Score stays at 7 before the 8th obstacle exits, then level=1 and the step interval shrinks from 4 to 3 cycles. At level>=2 the interval stays at 2 (TICK_MIN).
4. Assert gameover on the same cycle the counter reaches period-1 -> no shift, step stays 0, state HALT. blocks and score are frozen for 50 cycles; start pulses are ignored.
5. Force LFSR_SEED=16'h00FF (low byte FF, lfsr[10:8]=0) -> first obstacle row = 8'hFE. LFSR_SEED=16'h0500 -> first row = 8'h20.
6. Assert rst=0 mid-count in RUN with blocks nonzero -> blocks, score and step go to 0 asynchronously. After release, the module is in IDLE and a fresh start reproduces scenario 2 exactly.
